// File: rtl/truth_table_pkg.sv
// Shared constants and helpers for the 3-input parity / ones-count leaf.
package truth_table_pkg;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned ROWS  = 8;

    // Bit i holds the even-parity result for idx == i.
    localparam logic [ROWS-1:0] PARITY_LUT = 8'b1001_0110;

    function automatic logic [1:0] count_ones(input logic [IDX_W-1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/truth_table_cov.sv
// Sticky record of which {a,b,c} rows have been applied since the last reset.
module truth_table_cov
    import truth_table_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    output logic [ROWS-1:0]  seen,
    output logic             all_seen
);

    logic [ROWS-1:0] seen_d, seen_q;
    logic            all_seen_q;

    always_comb begin
        seen_d      = seen_q;
        seen_d[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q     <= '0;
            all_seen_q <= 1'b0;
        end else begin
            seen_q     <= seen_d;
            // Look at the next value so the flag rises on the completing edge.
            all_seen_q <= &seen_d;
        end
    end

    assign seen     = seen_q;
    assign all_seen = all_seen_q;

endmodule

// File: rtl/truth_table.sv
// 3-input parity generator with ones-count; coverage ports exist only when
// TRUTH_TABLE_COV_EN is defined.
module truth_table
    import truth_table_pkg::*;
#(
    parameter bit ODD_PARITY   = 1'b0,
    parameter bit REGISTER_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a,
    input  logic            b,
    input  logic            c,
    output logic            p,
`ifdef TRUTH_TABLE_COV_EN
    output logic [1:0]      ones,
    output logic [ROWS-1:0] seen,
    output logic            all_seen
`else
    output logic [1:0]      ones
`endif
);

    logic [IDX_W-1:0] idx;
    logic             p_d;
    logic [1:0]       ones_d;

    assign idx = {a, b, c};

    always_comb begin
        p_d    = PARITY_LUT[idx] ^ ODD_PARITY;
        ones_d = count_ones(idx);
    end

    if (REGISTER_OUT) begin : g_reg
        logic       p_q;
        logic [1:0] ones_q;

        // Reset value of p is the parity of row 000 for the selected sense.
        always_ff @(posedge clk) begin
            if (rst) begin
                p_q    <= ODD_PARITY;
                ones_q <= '0;
            end else begin
                p_q    <= p_d;
                ones_q <= ones_d;
            end
        end

        assign p    = p_q;
        assign ones = ones_q;
    end else begin : g_comb
        assign p    = p_d;
        assign ones = ones_d;
    end

`ifdef TRUTH_TABLE_COV_EN
    truth_table_cov u_cov (
        .clk      (clk),
        .rst      (rst),
        .idx      (idx),
        .seen     (seen),
        .all_seen (all_seen)
    );
`endif

endmodule

// File: tb/tb_truth_table.sv
// Table-driven bench for truth_table: even, odd and combinational variants.
module tb_truth_table;

    typedef struct {
        logic [2:0] abc;
        logic       p_even;
        logic       p_odd;
        logic [1:0] ones;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0;
    logic p0, p1, pc;
    logic [1:0] ones0, ones1, onesc;
`ifdef TRUTH_TABLE_COV_EN
    logic [7:0] seen0, seen1, seenc;
    logic       all0, all1, allc;
`endif

    int checks = 0;
    int errors = 0;
    vec_t vecs[8];

    always #5 clk = ~clk;

    truth_table #(.ODD_PARITY(1'b0), .REGISTER_OUT(1'b1)) u_even (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .p(p0),
`ifdef TRUTH_TABLE_COV_EN
        .ones(ones0), .seen(seen0), .all_seen(all0)
`else
        .ones(ones0)
`endif
    );

    truth_table #(.ODD_PARITY(1'b1), .REGISTER_OUT(1'b1)) u_odd (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .p(p1),
`ifdef TRUTH_TABLE_COV_EN
        .ones(ones1), .seen(seen1), .all_seen(all1)
`else
        .ones(ones1)
`endif
    );

    truth_table #(.ODD_PARITY(1'b0), .REGISTER_OUT(1'b0)) u_comb (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .p(pc),
`ifdef TRUTH_TABLE_COV_EN
        .ones(onesc), .seen(seenc), .all_seen(allc)
`else
        .ones(onesc)
`endif
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive on the falling edge, then sample 1 ns after the next rising edge.
    task automatic apply(input logic [2:0] abc, input logic r);
        @(negedge clk);
        {a, b, c} = abc;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_row(input string tag, input int i);
        chk({tag, " p_even"}, {7'd0, p0}, {7'd0, vecs[i].p_even});
        chk({tag, " p_odd"}, {7'd0, p1}, {7'd0, vecs[i].p_odd});
        chk({tag, " ones"}, {6'd0, ones0}, {6'd0, vecs[i].ones});
        chk({tag, " ones_odd"}, {6'd0, ones1}, {6'd0, vecs[i].ones});
    endtask

    initial begin
        vecs[0] = '{3'b000, 1'b0, 1'b1, 2'd0};
        vecs[1] = '{3'b001, 1'b1, 1'b0, 2'd1};
        vecs[2] = '{3'b010, 1'b1, 1'b0, 2'd1};
        vecs[3] = '{3'b011, 1'b0, 1'b1, 2'd2};
        vecs[4] = '{3'b100, 1'b1, 1'b0, 2'd1};
        vecs[5] = '{3'b101, 1'b0, 1'b1, 2'd2};
        vecs[6] = '{3'b110, 1'b0, 1'b1, 2'd2};
        vecs[7] = '{3'b111, 1'b1, 1'b0, 2'd3};

        // Reset held for two cycles with abc=111.
        for (int k = 0; k < 2; k++) begin
            apply(3'b111, 1'b1);
            chk("rst p_even", {7'd0, p0}, 8'd0);
            chk("rst p_odd", {7'd0, p1}, 8'd1);
            chk("rst ones", {6'd0, ones0}, 8'd0);
            chk("rst comb p", {7'd0, pc}, 8'd1);
            chk("rst comb ones", {6'd0, onesc}, 8'd3);
`ifdef TRUTH_TABLE_COV_EN
            chk("rst seen", seen0, 8'h00);
            chk("rst all_seen", {7'd0, all0}, 8'd0);
`endif
        end
        apply(3'b000, 1'b0);
        check_row("release", 0);

        // Exhaustive sweep; the combinational copy is checked before the edge too.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            {a, b, c} = vecs[i].abc;
            #1;
            chk("comb p", {7'd0, pc}, {7'd0, vecs[i].p_even});
            chk("comb ones", {6'd0, onesc}, {6'd0, vecs[i].ones});
            @(posedge clk);
            #1;
            check_row($sformatf("sweep row %0d", i), i);
        end
`ifdef TRUTH_TABLE_COV_EN
        chk("sweep seen", seen0, 8'hFF);
        chk("sweep all_seen", {7'd0, all0}, 8'd1);
`endif

        // Mid-sweep reset: rows 0..3, one reset cycle, then rows 4..7.
        for (int i = 0; i < 4; i++) begin
            apply(vecs[i].abc, 1'b0);
            check_row($sformatf("mid row %0d", i), i);
        end
        apply(3'b111, 1'b1);
        chk("mid rst p_even", {7'd0, p0}, 8'd0);
        chk("mid rst p_odd", {7'd0, p1}, 8'd1);
        chk("mid rst ones", {6'd0, ones0}, 8'd0);
`ifdef TRUTH_TABLE_COV_EN
        chk("mid rst seen", seen0, 8'h00);
        chk("mid rst all_seen", {7'd0, all0}, 8'd0);
`endif
        for (int i = 4; i < 8; i++) begin
            apply(vecs[i].abc, 1'b0);
            check_row($sformatf("resume row %0d", i), i);
        end
`ifdef TRUTH_TABLE_COV_EN
        chk("resume seen", seen0, 8'hF0);

        // Coverage sequence from a fresh reset.
        apply(3'b000, 1'b1);
        apply(3'b000, 1'b0);
        apply(3'b001, 1'b0);
        apply(3'b001, 1'b0);
        chk("cov repeat seen", seen0, 8'h03);
        apply(3'b111, 1'b0);
        chk("cov seen 83", seen0, 8'h83);
        chk("cov all_seen low", {7'd0, all0}, 8'd0);
        apply(3'b010, 1'b0);
        apply(3'b011, 1'b0);
        apply(3'b100, 1'b0);
        apply(3'b101, 1'b0);
        chk("cov seen BF", seen0, 8'hBF);
        chk("cov all_seen still low", {7'd0, all0}, 8'd0);
        apply(3'b110, 1'b0);
        chk("cov seen FF", seen0, 8'hFF);
        chk("cov all_seen", {7'd0, all0}, 8'd1);
        chk("cov comb seen", seenc, 8'hFF);
`endif

        // Combinational variant: change abc mid-cycle, with and without rst.
        @(posedge clk);
        #2;
        {a, b, c} = 3'b101;
        #1;
        chk("comb mid p", {7'd0, pc}, 8'd0);
        chk("comb mid ones", {6'd0, onesc}, 8'd2);
        rst = 1'b1;
        #1;
        chk("comb rst p", {7'd0, pc}, 8'd0);
        chk("comb rst ones", {6'd0, onesc}, 8'd2);
        {a, b, c} = 3'b110;
        #1;
        chk("comb rst p 110", {7'd0, pc}, 8'd0);
        chk("comb rst ones 110", {6'd0, onesc}, 8'd2);
        {a, b, c} = 3'b100;
        #1;
        chk("comb rst p 100", {7'd0, pc}, 8'd1);
        chk("comb rst ones 100", {6'd0, onesc}, 8'd1);
        rst = 1'b0;

        // A mid-cycle change must not reach the registered outputs before the edge.
        apply(3'b000, 1'b0);
        #2;
        {a, b, c} = 3'b111;
        #1;
        chk("hold p_even", {7'd0, p0}, 8'd0);
        chk("hold ones", {6'd0, ones0}, 8'd0);
        @(posedge clk);
        #1;
        check_row("after hold", 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
